// File: rtl/mem_burst_reader_if.sv
// Bundles the burst request, memory read port and output stream of mem_burst_reader.
// The master modport is the reader itself; the slave modport is its surrounding environment.
interface mem_burst_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              i_Start;
  logic [ADDR_W-1:0] i_Base_Addr;
  logic [ADDR_W:0]   i_Count;
  logic              i_Abort;
  logic              o_R_En;
  logic [ADDR_W-1:0] o_R_Addr;
  logic [DATA_W-1:0] i_R_Data;
  logic [DATA_W-1:0] o_Data;
  logic              o_Valid;
  logic              i_Ready;
  logic              o_Busy;
  logic              o_Done;

  modport master (
    input  i_Start, i_Base_Addr, i_Count, i_Abort, i_R_Data, i_Ready,
    output o_R_En, o_R_Addr, o_Data, o_Valid, o_Busy, o_Done
  );

  modport slave (
    output i_Start, i_Base_Addr, i_Count, i_Abort, i_R_Data, i_Ready,
    input  o_R_En, o_R_Addr, o_Data, o_Valid, o_Busy, o_Done
  );
endinterface

// File: rtl/mem_burst_reader.sv
// Burst read sequencer: walks consecutive addresses of a 1-cycle-latency memory
// and hands each byte to a valid/ready consumer, one beat per read.
module mem_burst_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input logic                i_Clk,
  input logic                i_Rst_n,
  mem_burst_reader_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_OUT     = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] cnt);
    if (cnt > MAX_CNT) begin
      clamp_count = MAX_CNT;
    end else begin
      clamp_count = cnt;
    end
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W-1:0]   addr_nxt_s;
  logic [ADDR_W:0]     rem_r;
  logic [ADDR_W:0]     rem_nxt_s;
  logic [ADDR_W:0]     start_cnt_s;
  logic                r_en_r;
  logic [ADDR_W-1:0]   r_addr_r;
  logic [DATA_W-1:0]   data_r;
  logic                valid_r;
  logic                busy_r;
  logic                done_r;

  assign start_cnt_s = clamp_count(bus.i_Count);

  // Next-state, next-address and remaining-beat logic.
  always_comb begin
    state_nxt_s = state_r;
    addr_nxt_s  = addr_r;
    rem_nxt_s   = rem_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_Start) begin
          addr_nxt_s = bus.i_Base_Addr;
          rem_nxt_s  = start_cnt_s;
          if (start_cnt_s == {(ADDR_W+1){1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_READ;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (bus.i_Abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (bus.i_Abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      ST_OUT: begin
        // Abort wins over a simultaneous accept: that beat is not counted.
        if (bus.i_Abort) begin
          state_nxt_s = ST_IDLE;
        end else if (bus.i_Ready) begin
          rem_nxt_s = rem_r - (ADDR_W+1)'(1);
          if (rem_r == (ADDR_W+1)'(1)) begin
            state_nxt_s = ST_DONE;
          end else begin
            addr_nxt_s  = addr_r + ADDR_W'(1);
            state_nxt_s = ST_READ;
          end
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and all outputs registered from the next state.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r  <= ST_IDLE;
      addr_r   <= {ADDR_W{1'b0}};
      rem_r    <= {(ADDR_W+1){1'b0}};
      r_en_r   <= 1'b0;
      r_addr_r <= {ADDR_W{1'b0}};
      data_r   <= {DATA_W{1'b0}};
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      addr_r  <= addr_nxt_s;
      rem_r   <= rem_nxt_s;
      r_en_r  <= (state_nxt_s == ST_READ);
      valid_r <= (state_nxt_s == ST_OUT);
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_nxt_s == ST_DONE);
      if (state_nxt_s == ST_READ) begin
        r_addr_r <= addr_nxt_s;
      end else begin
        r_addr_r <= r_addr_r;
      end
      // Memory data is only valid during CAPTURE; it is held through OUT.
      if ((state_r == ST_CAPTURE) && (state_nxt_s == ST_OUT)) begin
        data_r <= bus.i_R_Data;
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign bus.o_R_En   = r_en_r;
  assign bus.o_R_Addr = r_addr_r;
  assign bus.o_Data   = data_r;
  assign bus.o_Valid  = valid_r;
  assign bus.o_Busy   = busy_r;
  assign bus.o_Done   = done_r;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader with a 32x8 synchronous-read memory model
// preloaded so that mem[i] = i.
module tb_mem_burst_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_burst_reader_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  mem_burst_reader #(.ADDR_W(5), .DATA_W(8)) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  logic [7:0] mem [32];
  always_ff @(posedge clk) begin
    if (bus.o_R_En) bus.i_R_Data <= mem[bus.o_R_Addr];
  end

  typedef struct {
    int base;
    int cnt;
    int hold;        // cycles i_Ready stays low after the first o_Valid
    int abort_out;   // beat index whose OUT cycle gets i_Abort, -1 for none
    int restart_cyc; // cycle of a stray i_Start (also pulsed in DONE), -1 for none
    bit abort_start; // i_Abort raised together with i_Start
    int exp_beats;
    int exp_rens;
    int exp_done;    // cycle of o_Done, -1 for none
    int exp_fv;      // cycle of first o_Valid, -1 for none
  } vec_t;

  vec_t vecs[9];
  int n_tests = 0;
  int n_fail = 0;
  int got_addr[64];
  int got_cyc[64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int beats = 0;
    int rens = 0;
    int done_cyc = -1;
    int first_valid = -1;
    int stop_at = -1;
    bit finished = 1'b0;
    @(negedge clk);
    bus.i_Start     = 1'b1;
    bus.i_Base_Addr = 5'(v.base);
    bus.i_Count     = 6'(v.cnt);
    bus.i_Abort     = v.abort_start;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 150; cyc++) begin
      bus.i_Start = 1'b0;
      bus.i_Abort = 1'b0;
      bus.i_Ready = 1'b1;
      if (stop_at == cyc) begin
        check("busy_after_end", bus.o_Busy, 32'd0);
        check("valid_after_end", bus.o_Valid, 32'd0);
        check("done_after_end", bus.o_Done, 32'd0);
        finished = 1'b1;
        break;
      end
      if (bus.o_R_En) begin
        if (rens < 64) got_addr[rens] = bus.o_R_Addr;
        rens++;
      end
      if (bus.o_Done) begin
        done_cyc = cyc;
        stop_at = cyc + 1;
      end
      if (first_valid >= 0 && cyc < first_valid + v.hold)
        check("valid_held", bus.o_Valid, 32'd1);
      if (bus.o_Valid) begin
        if (first_valid < 0) first_valid = cyc;
        check("out_data", bus.o_Data, 32'((v.base + beats) % 32));
        if (cyc < first_valid + v.hold) bus.i_Ready = 1'b0;
        if (beats == v.abort_out) begin
          bus.i_Abort = 1'b1;
          stop_at = cyc + 1;
        end else if (bus.i_Ready) begin
          if (beats < 64) got_cyc[beats] = cyc;
          beats++;
        end
      end
      if (cyc == v.restart_cyc || (v.restart_cyc > 0 && bus.o_Done)) begin
        bus.i_Start     = 1'b1;
        bus.i_Base_Addr = 5'd10;
        bus.i_Count     = 6'd3;
      end
      @(posedge clk); #1;
    end
    bus.i_Start = 1'b0;
    bus.i_Abort = 1'b0;
    check("terminated", 32'(finished), 32'd1);
    check("beats", beats, v.exp_beats);
    check("read_enables", rens, v.exp_rens);
    check("done_cycle", done_cyc, v.exp_done);
    check("first_valid_cycle", first_valid, v.exp_fv);
    for (int k = 0; k < rens && k < 64; k++)
      check("read_addr", got_addr[k], (v.base + k) % 32);
    if (v.hold == 0 && v.abort_out < 0)
      for (int k = 0; k < beats && k < 64; k++)
        check("beat_cycle", got_cyc[k], 3 + 3 * k);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    bus.i_Start     = 1'b0;
    bus.i_Base_Addr = 5'd0;
    bus.i_Count     = 6'd0;
    bus.i_Abort     = 1'b0;
    bus.i_Ready     = 1'b1;

    //          base cnt hold abt rst as beats rens done fv
    vecs[0] = '{4,   3,  0,  -1, -1, 1'b0, 3,  3,  10, 3};
    vecs[1] = '{30,  4,  0,  -1, -1, 1'b0, 4,  4,  13, 3};
    vecs[2] = '{0,   0,  0,  -1, -1, 1'b0, 0,  0,  1,  -1};
    vecs[3] = '{0,   45, 0,  -1, -1, 1'b0, 32, 32, 97, 3};
    vecs[4] = '{0,   2,  5,  -1, -1, 1'b0, 2,  2,  12, 3};
    vecs[5] = '{0,   5,  0,  1,  -1, 1'b0, 1,  2,  -1, 3};
    vecs[6] = '{0,   3,  0,  -1, 2,  1'b0, 3,  3,  10, 3};
    vecs[7] = '{17,  1,  0,  -1, -1, 1'b1, 1,  1,  4,  3};
    vecs[8] = '{31,  32, 0,  -1, -1, 1'b0, 32, 32, 97, 3};

    repeat (3) @(posedge clk);
    #1;
    check("rst_r_en", bus.o_R_En, 32'd0);
    check("rst_r_addr", bus.o_R_Addr, 32'd0);
    check("rst_data", bus.o_Data, 32'd0);
    check("rst_valid", bus.o_Valid, 32'd0);
    check("rst_busy", bus.o_Busy, 32'd0);
    check("rst_done", bus.o_Done, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset pulled low while the block is in CAPTURE.
    @(negedge clk);
    bus.i_Start     = 1'b1;
    bus.i_Base_Addr = 5'd9;
    bus.i_Count     = 6'd3;
    @(posedge clk); #1;
    bus.i_Start = 1'b0;
    check("mid_read_r_en", bus.o_R_En, 32'd1);
    @(posedge clk); #1;
    check("mid_capture_busy", bus.o_Busy, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_r_en", bus.o_R_En, 32'd0);
    check("async_rst_r_addr", bus.o_R_Addr, 32'd0);
    check("async_rst_data", bus.o_Data, 32'd0);
    check("async_rst_valid", bus.o_Valid, 32'd0);
    check("async_rst_busy", bus.o_Busy, 32'd0);
    check("async_rst_done", bus.o_Done, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_burst_reader.md
Name: mem_burst_reader

Overview:
Read-side sequencer for the 32x8 synchronous-read scratch memory. On a start request it fetches a burst of consecutive bytes from a base address and presents them one at a time on a valid/ready stream to the downstream consumer, such as a UART TX or display driver. It owns the memory read port (r_en/r_addr) and absorbs the memory's 1-cycle read latency. The write port stays with the upstream producer.

Parameters:
ADDR_W, 5, memory address width (depth 2^ADDR_W = 32)
DATA_W, 8, memory and stream data width

Ports:
i_Clk  in  1  system clock, all logic on rising edge
i_Rst_n  in  1  asynchronous active-low reset
i_Start  in  1  burst request, sampled only in IDLE
i_Base_Addr  in  ADDR_W  first address of burst, latched with i_Start
i_Count  in  ADDR_W+1  burst length 0..63, latched with i_Start, clamped to 32
i_Abort  in  1  synchronous cancel of the burst in progress
o_R_En  out  1  memory read enable
o_R_Addr  out  ADDR_W  memory read address
i_R_Data  in  DATA_W  memory read data, valid the cycle after o_R_En
o_Data  out  DATA_W  stream data
o_Valid  out  1  stream data valid
i_Ready  in  1  downstream accepts o_Data when o_Valid && i_Ready
o_Busy  out  1  high in every state except IDLE
o_Done  out  1  one-cycle pulse when a burst completes normally

Behaviour:
- Clock and reset: one clock (i_Clk); reset is asynchronous and active-low (i_Rst_n).
- Reset value: state=IDLE. All outputs are 0: o_Data, o_Valid, o_R_En, o_R_Addr, o_Busy, o_Done. Internal address and remaining counters are 0.
- Reset asserted mid-burst returns the block to IDLE immediately. No o_Done is produced.
- FSM states: IDLE, READ, CAPTURE, OUT, DONE.
- IDLE:
  - On i_Start=1, latch addr=i_Base_Addr and rem=min(i_Count,32).
  - rem==0 goes to DONE; otherwise go to READ.
- READ (1 cycle):
  - o_R_En=1 and o_R_Addr=addr.
  - Next state is CAPTURE.
  - o_R_En is 1 only in READ. o_R_Addr holds its last value elsewhere.
- CAPTURE (1 cycle):
  - i_R_Data is valid this cycle and is registered into o_Data at the cycle end.
  - o_Valid rises at the same edge. Next state is OUT.
- OUT:
  - o_Valid=1 and o_Data is held stable until accepted.
  - On i_Ready=1, the beat is accepted and rem decrements.
  - If rem was 1, o_Valid clears and the next state is DONE.
  - Otherwise addr increments modulo 32 (31 wraps to 0), o_Valid clears and the next state is READ.
  - No beat is ever dropped or duplicated.
- DONE (1 cycle): o_Done=1, then go to IDLE. o_Busy is high in DONE.
- Timing:
  - Start sampled at edge 0: READ in cycle 1, CAPTURE in cycle 2, o_Valid high in cycle 3.
  - Steady-state beat period is 3 cycles with i_Ready held high.
- i_Start in any non-IDLE state is ignored, including in DONE.
- i_Abort:
  - In READ, CAPTURE, OUT or DONE, it forces IDLE at the next edge with o_Valid=0 and o_Done=0.
  - It has priority over beat acceptance in the same cycle. The beat is counted as not transferred.
  - i_Abort in IDLE has no effect. i_Abort and i_Start together in IDLE: the start is taken.
- A concurrent upstream write to the same address as the read in the READ cycle returns the old data. This is the memory's read-before-write behaviour; the block does not compensate for it.
- Width rules:
  - rem is ADDR_W+1 bits.
  - i_Count values 33..63 clamp to 32, and 32 is a full-memory burst.

Test Plan:
- Memory preloaded 0x00..0x1F at addresses 0..31; start base=4, count=3, ready=1 -> o_Data 0x04, 0x05, 0x06 on cycles 3, 6, 9; o_Done pulse on cycle 10; o_Busy low on cycle 11.
- Wrap: base=30, count=4 -> reads at addresses 30, 31, 0, 1; data 0x1E, 0x1F, 0x00, 0x01.
- Backpressure: base=0, count=2, i_Ready low for 5 cycles after the first o_Valid -> o_Data=0x00 stays stable with o_Valid=1 throughout; exactly 2 beats are delivered; o_R_En fires exactly twice.
- Boundaries:
  - count=0 -> no o_R_En, o_Valid stays 0, o_Done pulses in cycle 1.
  - count=45 -> exactly 32 beats, 0x00..0x1F when base=0.
- Abort and reset: abort asserted during the second OUT of a count=5 burst, with i_Ready=1 -> IDLE next cycle, no o_Done, only 1 beat counted; a new start then works. Separately, i_Rst_n pulled low in CAPTURE -> all outputs 0 immediately.
- Start while busy: i_Start pulsed with base=10 during a base=0, count=3 burst -> ignored; the data stream is 0x00, 0x01, 0x02.
